// File: rtl/key_debounce_if.sv
// Key bundle between raw key pins and the debounced level/strobe outputs.
// master drives the raw pins; slave (the debouncer) returns clean signals.
interface key_debounce_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser, debounce counter and 4-state FSM giving clean level and strobes.
// Define KEY_DEBOUNCE_LONGPRESS_EN to add the per-key hold counter and key_long strobe.
module key_debounce #(
  parameter int N_KEYS      = 2,
  parameter int DB_CYCLES   = 270000,
  parameter int LONG_CYCLES = 27000000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic         clk,
  input  logic         rstn,
  key_debounce_if.slave kb
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int                 CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
    $error("key_debounce: DB_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic [N_KEYS-1:0] raw_act;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  assign raw_act = (ACTIVE_LOW != 0) ? ~kb.key_raw : kb.key_raw;

  // Synchroniser stage: resets to the released level so no press appears out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_act;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign s = sync2_q[k];

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    // FSM stage: level and strobes are registered so they change on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign kb.key_level[k]   = level_q;
    assign kb.key_press[k]   = press_q;
    assign kb.key_release[k] = release_q;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Saturating hold counter; reaching LONG_MAX is what stops a second strobe.
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_d == IDLE) begin
        hold_d = '0;
      end else if (state_q == PRESS_WAIT && state_d == HELD) begin
        hold_d = '0;
      end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
        if (hold_q != LONG_MAX) hold_d = hold_q + 1'b1;
        if (hold_q == LONG_LAST) long_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign kb.key_long[k] = long_q;
`else
    assign kb.key_long[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected outputs are queued per cycle when stimulus is
// driven and compared by a negedge monitor when that cycle arrives.
module tb_key_debounce;

  localparam int N_KEYS      = 2;
  localparam int DB_CYCLES   = 4;
  localparam int LONG_CYCLES = 20;
  localparam int ACTIVE_LOW  = 0;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    string      tag;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  key_debounce_if #(.N_KEYS(N_KEYS)) bus ();

  key_debounce #(
    .N_KEYS     (N_KEYS),
    .DB_CYCLES  (DB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .kb  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] expv;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs  = {bus.key_level, bus.key_press, bus.key_release, bus.key_long};
        expv = {sb[i].lvl, sb[i].prs, sb[i].rel, sb[i].lng};
        n_checks++;
        assert (obs === expv) else begin
          n_fail++;
          $error("FAIL %s cyc %0d: observed lvl/prs/rel/lng=%b expected %b",
                 sb[i].tag, cyc, obs, expv);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push_exp(input int at, input logic [1:0] lvl, input logic [1:0] prs,
                          input logic [1:0] rel, input logic [1:0] lng, input string tag);
    exp_t e;
    e.cyc = at; e.lvl = lvl; e.prs = prs; e.rel = rel; e.lng = lng; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic quiet(input int t0, input int from, input int to, input logic [1:0] lvl,
                       input string tag);
    for (int k = from; k <= to; k++) push_exp(t0 + k, lvl, 2'b00, 2'b00, 2'b00, tag);
  endtask

  task automatic drive(input logic [1:0] v, output int t);
    @(negedge clk);
    bus.key_raw = v;
    t = cyc;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_now(input logic [7:0] expv, input string tag);
    logic [7:0] obs;
    obs = {bus.key_level, bus.key_press, bus.key_release, bus.key_long};
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed lvl/prs/rel/lng=%b expected %b", tag, obs, expv);
    end
  endtask

  initial begin
    int t, t2, tmp;
    bus.key_raw = 2'b11;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    // Reset state with both keys down, then fresh press of both after release of reset.
    wait_n(3);
    check_now(8'h00, "reset_state");
    @(negedge clk);
    rstn = 1'b1;
    t = cyc;
    quiet(t, 1, 6, 2'b00, "rst_pre");
    push_exp(t + 7, 2'b11, 2'b11, 2'b00, 2'b00, "rst_press");
    quiet(t, 8, 8, 2'b11, "rst_post");
    wait_n(8);
    drive(2'b00, t);
    quiet(t, 1, 6, 2'b11, "rst_relwait");
    push_exp(t + 7, 2'b00, 2'b00, 2'b11, 2'b00, "rst_release");
    quiet(t, 8, 8, 2'b00, "rst_idle");
    wait_n(8);

    // Clean press and release of key 0.
    drive(2'b01, t);
    quiet(t, 1, 6, 2'b00, "clean_pre");
    push_exp(t + 7, 2'b01, 2'b01, 2'b00, 2'b00, "clean_press");
    quiet(t, 8, 10, 2'b01, "clean_held");
    wait_n(10);
    drive(2'b00, t);
    quiet(t, 1, 6, 2'b01, "clean_relwait");
    push_exp(t + 7, 2'b00, 2'b00, 2'b01, 2'b00, "clean_release");
    quiet(t, 8, 8, 2'b00, "clean_idle");
    wait_n(8);

    // Press bounce: 1,0,1,0 every 2 cycles then 0 must never be accepted.
    drive(2'b01, t);
    quiet(t, 1, 16, 2'b00, "bounce");
    wait_n(1);
    drive(2'b00, tmp);
    wait_n(1);
    drive(2'b01, tmp);
    wait_n(1);
    drive(2'b00, tmp);
    wait_n(11);

    // Release bounce: 3 cycles low while held must not release.
    drive(2'b01, t);
    quiet(t, 1, 6, 2'b00, "rb_pre");
    push_exp(t + 7, 2'b01, 2'b01, 2'b00, 2'b00, "rb_press");
    quiet(t, 8, 8, 2'b01, "rb_held");
    wait_n(8);
    drive(2'b00, t2);
    quiet(t2, 1, 8, 2'b01, "rel_bounce");
    wait_n(2);
    drive(2'b01, tmp);
    wait_n(5);
    drive(2'b00, t);
    quiet(t, 1, 6, 2'b01, "rb_relwait");
    push_exp(t + 7, 2'b00, 2'b00, 2'b01, 2'b00, "rb_release");
    quiet(t, 8, 8, 2'b00, "rb_idle");
    wait_n(8);

    // Independence: key 1 pressed two cycles after key 0.
    drive(2'b01, t);
    quiet(t, 1, 6, 2'b00, "ind_pre");
    push_exp(t + 7, 2'b01, 2'b01, 2'b00, 2'b00, "ind_press0");
    quiet(t, 8, 8, 2'b01, "ind_mid");
    push_exp(t + 9, 2'b11, 2'b10, 2'b00, 2'b00, "ind_press1");
    quiet(t, 10, 10, 2'b11, "ind_both");
    wait_n(1);
    drive(2'b11, tmp);
    wait_n(8);
    drive(2'b00, t);
    quiet(t, 1, 6, 2'b11, "ind_relwait");
    push_exp(t + 7, 2'b00, 2'b00, 2'b11, 2'b00, "ind_release");
    quiet(t, 8, 8, 2'b00, "ind_idle");
    wait_n(8);

    // Long hold on key 0: a single key_long pulse 20 cycles after the press when enabled.
    drive(2'b01, t);
    quiet(t, 1, 6, 2'b00, "long_pre");
    push_exp(t + 7, 2'b01, 2'b01, 2'b00, 2'b00, "long_press");
    for (int k = 8; k <= 40; k++)
      push_exp(t + k, 2'b01, 2'b00, 2'b00,
               (LONG_EN && k == 7 + LONG_CYCLES) ? 2'b01 : 2'b00, "long_hold");
    wait_n(40);
    drive(2'b00, t);
    quiet(t, 1, 6, 2'b01, "long_relwait");
    push_exp(t + 7, 2'b00, 2'b00, 2'b01, 2'b00, "long_release");
    quiet(t, 8, 8, 2'b00, "long_idle");
    wait_n(8);

    // Mid-operation reset while both keys held: outputs drop at once, no release strobe.
    drive(2'b11, t);
    quiet(t, 1, 6, 2'b00, "mid_pre");
    push_exp(t + 7, 2'b11, 2'b11, 2'b00, 2'b00, "mid_press");
    quiet(t, 8, 8, 2'b11, "mid_held");
    wait_n(8);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_now(8'h00, "midrst_immediate");
    repeat (3) begin
      @(negedge clk);
      check_now(8'h00, "midrst_hold");
    end
    @(negedge clk);
    rstn = 1'b1;
    t = cyc;
    quiet(t, 1, 6, 2'b00, "midrst_pre");
    push_exp(t + 7, 2'b11, 2'b11, 2'b00, 2'b00, "midrst_press");
    quiet(t, 8, 8, 2'b11, "midrst_held");
    wait_n(8);
    drive(2'b00, t);
    quiet(t, 1, 6, 2'b11, "midrst_relwait");
    push_exp(t + 7, 2'b00, 2'b00, 2'b11, 2'b00, "midrst_release");
    quiet(t, 8, 8, 2'b00, "midrst_idle");
    wait_n(10);

    n_checks++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
